// File: rtl/mcycle_unit_if.sv
// Request/response bundle between the decoder and the multi-cycle unit.
// The decoder is master; mcycle_unit is slave.
interface mcycle_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp,
    output Operand1, Operand2,
    input  Result1, Result2,
    input  Busy, Done
  );

  modport slave (
    input  Start, MCycleOp,
    input  Operand1, Operand2,
    output Result1, Result2,
    output Busy, Done
  );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative 32-bit mul/div unit: shift-add multiply, restoring divide.
// Optional MCYCLE_EARLY_EXIT_EN: early exit on exhausted multiplier or div-by-zero.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input logic         CLK,
  input logic         RESET,
  mcycle_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_mul;
  logic               neg_lo;
  logic               neg_hi;
  logic               dz;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   op1_raw;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   res1;
  logic [WIDTH-1:0]   res2;

  logic               sgn;
  logic               s1;
  logic               s2;
  logic               op_mul;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic               early;
  logic               finish;

  assign sgn    = bus.MCycleOp[1];
  assign op_mul = bus.MCycleOp[1] == bus.MCycleOp[0];
  assign s1     = sgn & bus.Operand1[WIDTH-1];
  assign s2     = sgn & bus.Operand2[WIDTH-1];
  assign abs1   = s1 ? -bus.Operand1 : bus.Operand1;
  assign abs2   = s2 ? -bus.Operand2 : bus.Operand2;

  // Restoring step: remainder never exceeds divisor, so WIDTH+1 bits suffice
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  assign prod  = acc + (quo[0] ? mcand : '0);
  assign mul_p = neg_lo ? -acc : acc;
  assign q_fix = neg_lo ? -quo : quo;
  assign r_fix = neg_hi ? -rem : rem;

`ifdef MCYCLE_EARLY_EXIT_EN
  assign early = is_mul ? (cnt != '0) && (quo == '0) : dz;
`else
  assign early = 1'b0;
`endif

  assign finish = (cnt == LAST) || early;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      is_mul  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      dz      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      op1_raw <= '0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
      acc     <= '0;
      mcand   <= '0;
      res1    <= '0;
      res2    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.Start) begin
            state   <= COMPUTE;
            busy    <= 1'b1;
            cnt     <= '0;
            is_mul  <= op_mul;
            neg_lo  <= s1 ^ s2;
            neg_hi  <= s1;
            dz      <= bus.Operand2 == '0;
            op1_raw <= bus.Operand1;
            divisor <= abs2;
            quo     <= op_mul ? abs2 : abs1;
            rem     <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, abs1};
          end
        end
        COMPUTE: begin
          if (finish) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (is_mul) begin
              res1 <= mul_p[WIDTH-1:0];
              res2 <= mul_p[2*WIDTH-1:WIDTH];
            end else if (dz) begin
              res1 <= '1;
              res2 <= op1_raw;
            end else begin
              res1 <= q_fix;
              res2 <= r_fix;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (is_mul) begin
              acc   <= prod;
              mcand <= mcand << 1;
              quo   <= quo >> 1;
            end else if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.Result1 = res1;
  assign bus.Result2 = res2;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed scoreboard bench for mcycle_unit (default fixed-latency build).
module tb_mcycle_unit;

  localparam logic [1:0] UMUL = 2'b00;
  localparam logic [1:0] UDIV = 2'b01;
  localparam logic [1:0] SDIV = 2'b10;
  localparam logic [1:0] SMUL = 2'b11;
  localparam int LAT = 33;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    string       tag;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  mcycle_unit_if #(.WIDTH(32)) bus ();

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] e1,
                          input logic [31:0] e2,
                          input string tag);
    sb.push_back('{r1: e1, r2: e2, tag: tag});
    @(negedge CLK);
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    @(posedge CLK);
  endtask

  // Called right after the edge that sampled Start
  task automatic finish_op(input bit hold);
    int   edges;
    bit   got;
    bit   busy_ok;
    exp_t e;
    edges   = 0;
    got     = 0;
    busy_ok = 1;
    while (!got && edges < 100) begin
      @(negedge CLK);
      if (bus.Done === 1'b1) begin
        got = 1;
      end else begin
        if (bus.Busy !== 1'b1) busy_ok = 0;
        if (edges == 5 && !hold) begin
          bus.Operand1 = $urandom;
          bus.Operand2 = $urandom;
          bus.MCycleOp = 2'($urandom_range(0, 3));
        end
        @(posedge CLK);
        edges++;
      end
    end
    e = sb.pop_front();
    check({e.tag, "_timeout"}, 64'(got), 64'd1);
    check({e.tag, "_latency"}, 64'(edges), 64'(LAT));
    check({e.tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({e.tag, "_busy_in_done"}, 64'(bus.Busy), 64'd0);
    check({e.tag, "_r1"}, 64'(bus.Result1), 64'(e.r1));
    check({e.tag, "_r2"}, 64'(bus.Result2), 64'(e.r2));
    if (!hold) bus.Start = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check({e.tag, "_pulse"}, 64'(bus.Done), 64'd0);
    check({e.tag, "_idle"}, 64'(bus.Busy), 64'd0);
    check({e.tag, "_hold_r1"}, 64'(bus.Result1), 64'(e.r1));
  endtask

  initial begin
    bus.Start    = 1'b0;
    bus.MCycleOp = UMUL;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    #1;
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_r1", 64'(bus.Result1), 64'd0);
    check("rst_r2", 64'(bus.Result2), 64'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    start_op(UMUL, 32'h0001_0000, 32'h0001_0000,
             32'h0000_0000, 32'h0000_0001, "umul");
    finish_op(0);
    start_op(UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'h0000_0001, 32'hFFFF_FFFE, "umul_max");
    finish_op(0);
    start_op(SMUL, 32'hFFFF_FFFD, 32'h0000_0005,
             32'hFFFF_FFF1, 32'hFFFF_FFFF, "smul");
    finish_op(0);
    start_op(SMUL, 32'h8000_0000, 32'h8000_0000,
             32'h0000_0000, 32'h4000_0000, "smul_min");
    finish_op(0);
    start_op(UDIV, 32'd100, 32'd7,
             32'd14, 32'd2, "udiv");
    finish_op(0);
    start_op(SDIV, 32'hFFFF_FF9C, 32'd7,
             32'hFFFF_FFF2, 32'hFFFF_FFFE, "sdiv_neg");
    finish_op(0);
    start_op(SDIV, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000, 32'h0000_0000, "sdiv_ovf");
    finish_op(0);
    start_op(SDIV, 32'hFFFF_FFF9, 32'd0,
             32'hFFFF_FFFF, 32'hFFFF_FFF9, "sdiv_dz");
    finish_op(0);
    start_op(UDIV, 32'd5, 32'd0,
             32'hFFFF_FFFF, 32'd5, "udiv_dz");
    finish_op(0);

    // Abort a divide mid-flight
    @(negedge CLK);
    bus.Start    = 1'b1;
    bus.MCycleOp = UDIV;
    bus.Operand1 = 32'd1000;
    bus.Operand2 = 32'd7;
    @(posedge CLK);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    check("mid_busy", 64'(bus.Busy), 64'd1);
    RESET = 1'b1;
    #1;
    check("abort_busy", 64'(bus.Busy), 64'd0);
    check("abort_done", 64'(bus.Done), 64'd0);
    check("abort_r1", 64'(bus.Result1), 64'd0);
    check("abort_r2", 64'(bus.Result2), 64'd0);
    bus.Start = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("post_rst_busy", 64'(bus.Busy), 64'd0);

    // Start held through DONE: ignored there, re-sampled in IDLE
    start_op(UDIV, 32'd9, 32'd3, 32'd3, 32'd0, "b2b_a");
    finish_op(1);
    sb.push_back('{r1: 32'd3, r2: 32'd0, tag: "b2b_b"});
    @(posedge CLK);
    finish_op(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
